// File: rtl/exp_cfg_pkg.sv
// Shared constants and FSM state encoding for the BF16 piecewise-linear exp
// coefficient table and its loader.
package exp_cfg_pkg;

  localparam int N_IDX  = 13;
  localparam int N_SGN  = 2;
  localparam int BASE_W = 16;
  localparam int OFF_W  = 26;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_BASE = 3'd1,
    S_GET_OFF  = 3'd2,
    S_WRITE    = 3'd3,
    S_FINISH   = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IDX - 1);
  localparam logic             SGN_LAST = 1'(N_SGN - 1);

endpackage

// File: rtl/exp_table_loader_if.sv
// Coefficient stream input plus the register-file write port of the exp MAC.
// Stream: a word transfers on a rising clock edge where in_valid and in_ready are
// both 1; in_data must hold while in_valid=1 and in_ready=0.
interface exp_table_loader_if;
  import exp_cfg_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              cfg_w_en;
  logic              cfg_sgn;
  logic [IDX_W-1:0]  cfg_idx;
  logic [BASE_W-1:0] cfg_base;
  logic [OFF_W-1:0]  cfg_offset;

  modport slave (
    input  in_valid, in_data,
    output in_ready, cfg_w_en, cfg_sgn, cfg_idx, cfg_base, cfg_offset
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, cfg_w_en, cfg_sgn, cfg_idx, cfg_base, cfg_offset
  );

endinterface

// File: rtl/exp_table_loader.sv
// Loads 26 base/offset pairs from a word stream into the exp MAC register file,
// in bank 0 then bank 1 order, and flags table_valid after a clean full load.
module exp_table_loader
  import exp_cfg_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  exp_table_loader_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                table_valid,
  output state_t              dbg_state
);

  state_t            state, state_nxt;
  logic              sgn;
  logic [IDX_W-1:0]  idx;
  logic [BASE_W-1:0] base_q;
  logic [OFF_W-1:0]  off_q;

  logic accept;
  logic base_bad;
  logic off_bad;
  logic last_entry;
  logic can_start;

  assign accept     = bus.in_valid & bus.in_ready;
  assign base_bad   = |bus.in_data[DATA_W-1:BASE_W];
  assign off_bad    = |bus.in_data[DATA_W-1:OFF_W];
  assign last_entry = (sgn == SGN_LAST) && (idx == IDX_LAST);
  assign can_start  = start && ((state == S_IDLE) || (state == S_ERROR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_GET_BASE;
      S_GET_BASE: if (accept) state_nxt = base_bad ? S_ERROR : S_GET_OFF;
      S_GET_OFF:  if (accept) state_nxt = off_bad ? S_ERROR : S_WRITE;
      S_WRITE:    state_nxt = last_entry ? S_FINISH : S_GET_BASE;
      S_FINISH:   state_nxt = S_IDLE;
      S_ERROR:    if (start) state_nxt = S_GET_BASE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.cfg_w_en = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_GET_BASE: begin bus.in_ready = 1'b1; busy = 1'b1; end
      S_GET_OFF:  begin bus.in_ready = 1'b1; busy = 1'b1; end
      S_WRITE:    begin bus.cfg_w_en = 1'b1; busy = 1'b1; end
      S_FINISH:   begin done = 1'b1; busy = 1'b1; end
      default:    ;
    endcase
  end

  // Counters advance on the edge leaving WRITE, so cfg_* hold the current entry
  // for the whole strobe cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn         <= 1'b0;
      idx         <= '0;
      base_q      <= '0;
      off_q       <= '0;
      err         <= 1'b0;
      table_valid <= 1'b0;
    end else if (can_start) begin
      sgn         <= 1'b0;
      idx         <= '0;
      err         <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      case (state)
        S_GET_BASE: if (accept) begin
          if (base_bad) err    <= 1'b1;
          else          base_q <= bus.in_data[BASE_W-1:0];
        end
        S_GET_OFF: if (accept) begin
          if (off_bad) err   <= 1'b1;
          else         off_q <= bus.in_data[OFF_W-1:0];
        end
        S_WRITE: begin
          if (idx == IDX_LAST) begin
            idx <= '0;
            sgn <= sgn + 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_FINISH: table_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.cfg_sgn    = sgn;
  assign bus.cfg_idx    = idx;
  assign bus.cfg_base   = base_q;
  assign bus.cfg_offset = off_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_exp_table_loader.sv
// Bench for exp_table_loader: random coefficient loads with stalls, error
// injection, ignored restart and mid-load reset, scored against an entry list.
module tb_exp_table_loader;
  import exp_cfg_pkg::*;

  localparam int N_ENT = N_SGN * N_IDX;
  localparam int ENT_W = 1 + IDX_W + BASE_W + OFF_W;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   start = 1'b0;
  logic   busy, done, err, table_valid;
  state_t dbg_state;

  exp_table_loader_if bus();

  exp_table_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .table_valid (table_valid),
    .dbg_state   (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // checking
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard and MAC table model
  logic [ENT_W-1:0]  exp_q[$];
  logic [ENT_W-1:0]  obs_q[$];
  logic [BASE_W-1:0] mac_base[N_SGN][N_IDX];
  logic [OFF_W-1:0]  mac_off[N_SGN][N_IDX];
  int last_w_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int start_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (bus.cfg_w_en) begin
      obs_q.push_back({bus.cfg_sgn, bus.cfg_idx, bus.cfg_base, bus.cfg_offset});
      last_w_cyc = cyc;
      if (int'(bus.cfg_idx) < N_IDX) begin
        mac_base[bus.cfg_sgn][bus.cfg_idx] = bus.cfg_base;
        mac_off[bus.cfg_sgn][bus.cfg_idx]  = bus.cfg_offset;
      end
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
  end

  // stimulus values per entry, entry e = sgn*N_IDX + idx
  logic [BASE_W-1:0] ent_base[N_ENT];
  logic [OFF_W-1:0]  ent_off[N_ENT];

  function automatic logic [ENT_W-1:0] entry_word(input int e);
    logic             s;
    logic [IDX_W-1:0] i;
    s = 1'(e / N_IDX);
    i = IDX_W'(e % N_IDX);
    return {s, i, ent_base[e], ent_off[e]};
  endfunction

  // driver tasks
  task automatic send_beat(input logic [DATA_W-1:0] data, input int idle_pct, output bit ok);
    int guard;
    guard = 0;
    ok = 1'b0;
    bus.in_data = data;
    while (!ok && guard < 200) begin
      bus.in_valid = ($urandom_range(0, 99) >= idle_pct);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int g = 0; g < 12 && done_cnt == d0; g++) begin
      @(negedge clk);
      #1;
    end
    check("done_seen", 64'(done_cnt - d0), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    check("done_single", 64'(done_cnt - d0), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int idle_pct, input int bad_entry, input int restart_entry,
                          input int reset_entry);
    bit ok;
    int d0;
    d0 = done_cnt;
    pulse_start();
    for (int e = 0; e < N_ENT; e++) begin
      if (e == restart_entry) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      if (e == bad_entry) begin
        send_beat({16'h0001, ent_base[e]}, idle_pct, ok);
        check("bad_beat_accept", 64'(ok), 64'd1);
        return;
      end
      send_beat({{(DATA_W-BASE_W){1'b0}}, ent_base[e]}, idle_pct, ok);
      check("beat_a_accept", 64'(ok), 64'd1);
      if (e == reset_entry) begin
        rst_n = 1'b0;
        #1;
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_ready", 64'(bus.in_ready), 64'd0);
        check("rst_async_w_en", 64'(bus.cfg_w_en), 64'd0);
        check("rst_async_state", 64'(dbg_state), 64'(S_IDLE));
        check("rst_async_base", 64'(bus.cfg_base), 64'd0);
        check("rst_async_idx", 64'(bus.cfg_idx), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      send_beat({{(DATA_W-OFF_W){1'b0}}, ent_off[e]}, idle_pct, ok);
      check("beat_b_accept", 64'(ok), 64'd1);
      exp_q.push_back(entry_word(e));
    end
    wait_done(d0);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_n_writes"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_write"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_table(input string tag);
    for (int e = 0; e < N_ENT; e++) begin
      check({tag, "_mac_base"}, 64'(mac_base[e / N_IDX][e % N_IDX]), 64'(ent_base[e]));
      check({tag, "_mac_off"}, 64'(mac_off[e / N_IDX][e % N_IDX]), 64'(ent_off[e]));
    end
  endtask

  task automatic randomize_entries();
    for (int e = 0; e < N_ENT; e++) begin
      ent_base[e] = BASE_W'($urandom);
      ent_off[e]  = OFF_W'($urandom);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // reset, then idle
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle_ready", 64'(bus.in_ready), 64'd0);
    check("idle_w_en", 64'(bus.cfg_w_en), 64'd0);
    check("idle_sgn", 64'(bus.cfg_sgn), 64'd0);
    check("idle_idx", 64'(bus.cfg_idx), 64'd0);
    check("idle_base", 64'(bus.cfg_base), 64'd0);
    check("idle_off", 64'(bus.cfg_offset), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_err", 64'(err), 64'd0);
    check("idle_tv", 64'(table_valid), 64'd0);
    check("idle_state", 64'(dbg_state), 64'(S_IDLE));

    // back-to-back deterministic load
    for (int e = 0; e < N_ENT; e++) begin
      ent_base[e] = BASE_W'(16'h3F80 + e);
      ent_off[e]  = OFF_W'(e * 3);
    end
    run_load(0, -1, -1, -1);
    compare_writes("b2b");
    check("b2b_last_write_cyc", 64'(last_w_cyc - start_cyc), 64'd78);
    check("b2b_done_cyc", 64'(done_cyc - start_cyc), 64'd79);
    check("b2b_tv", 64'(table_valid), 64'd1);
    check("b2b_err", 64'(err), 64'd0);
    check_table("b2b");

    // random values, 50% stalls
    randomize_entries();
    run_load(50, -1, -1, -1);
    compare_writes("stall");
    check("stall_tv", 64'(table_valid), 64'd1);
    check_table("stall");

    // reserved bits set in beat A of entry 5
    randomize_entries();
    run_load(30, 5, -1, -1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_writes("err");
    check("err_flag", 64'(err), 64'd1);
    check("err_state", 64'(dbg_state), 64'(S_ERROR));
    check("err_tv", 64'(table_valid), 64'd0);
    check("err_busy", 64'(busy), 64'd0);
    check("err_ready", 64'(bus.in_ready), 64'd0);
    run_load(20, -1, -1, -1);
    compare_writes("recover");
    check("recover_tv", 64'(table_valid), 64'd1);
    check("recover_err", 64'(err), 64'd0);

    // start while busy at entry 7 is ignored
    randomize_entries();
    run_load(25, -1, 7, -1);
    compare_writes("restart");
    check("restart_tv", 64'(table_valid), 64'd1);
    check_table("restart");

    // reset during entry 10
    randomize_entries();
    run_load(10, -1, -1, 10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_writes("reset");
    check("reset_state", 64'(dbg_state), 64'(S_IDLE));
    check("reset_tv", 64'(table_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
